paralelo_serial_param: RTL

- Parametrised successor to the 8-bit parallel-to-2-bit-serial converter.
- Single fast-clock domain; replaces the separate clk4f/clk16f pair with a valid/ready handshake on the parallel side.
- Serialises DATA_W-bit words into LANE_W-bit slices, MSB slice first.
- After reset, sends a sync preamble of idle characters, then substitutes the idle character for any word slot with no valid data.

---
 rtl/paralelo_serial_param.sv | 133 +++++++++++++
 1 files changed

// File: rtl/paralelo_serial_param.sv
// Parametrised parallel-to-serial converter: DATA_W-bit words out as LANE_W-bit slices, MSB first,
// with a valid/ready input, a sync preamble of idle characters and idle fill.
// Optional `PARALELO_SERIAL_WORDCNT_EN adds a 16-bit count of data words sent (words_sent).
module paralelo_serial_param #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       LANE_W     = 2,
  parameter logic [DATA_W-1:0] IDLE_CHAR  = 8'hBC,
  parameter int unsigned       SYNC_WORDS = 4
) (
  input  logic              clk16f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LANE_W-1:0] serial_out,
  output logic              word_start,
  output logic              idle_out,
  output logic              active
`ifdef PARALELO_SERIAL_WORDCNT_EN
  ,
  output logic [15:0]       words_sent
`endif
);

  localparam int unsigned SLICES = DATA_W / LANE_W;
  localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned SYNC_W = $clog2(SYNC_WORDS + 1);

  localparam logic [CNT_W-1:0]  LastSlice = CNT_W'(SLICES - 1);
  localparam logic [SYNC_W-1:0] LastSync  = SYNC_W'(SYNC_WORDS - 1);

  typedef enum logic [0:0] {StSync, StActive} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    slice_cnt_q, slice_cnt_d;
  logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                word_start_q, word_start_d;
  logic                idle_out_q, idle_out_d;
`ifdef PARALELO_SERIAL_WORDCNT_EN
  logic [15:0]         words_sent_q, words_sent_d;
`endif

  logic load;
  logic xfer;

  assign load     = (slice_cnt_q == LastSlice);
  assign in_ready = (state_q == StActive) && (!hold_full_q || load);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    slice_cnt_d  = slice_cnt_q;
    sync_cnt_d   = sync_cnt_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    word_start_d = word_start_q;
    idle_out_d   = idle_out_q;
`ifdef PARALELO_SERIAL_WORDCNT_EN
    words_sent_d = words_sent_q;
`endif

    if (load) begin
      slice_cnt_d  = '0;
      word_start_d = 1'b1;
      if (state_q == StActive && hold_full_q) begin
        shreg_d     = hold_q;
        hold_full_d = 1'b0;
        idle_out_d  = 1'b0;
`ifdef PARALELO_SERIAL_WORDCNT_EN
        words_sent_d = words_sent_q + 16'd1;
`endif
      end else begin
        shreg_d    = IDLE_CHAR;
        idle_out_d = 1'b1;
      end
      if (state_q == StSync) begin
        sync_cnt_d = sync_cnt_q + 1'b1;
        if (sync_cnt_q == LastSync) state_d = StActive;
      end
    end else begin
      slice_cnt_d  = slice_cnt_q + 1'b1;
      shreg_d      = shreg_q << LANE_W;
      word_start_d = 1'b0;
    end

    // A transfer on a load edge refills hold after the load has taken the old word.
    if (xfer) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk16f) begin
    if (!reset_L) begin
      state_q      <= StSync;
      slice_cnt_q  <= LastSlice;
      sync_cnt_q   <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      word_start_q <= 1'b0;
      idle_out_q   <= 1'b0;
`ifdef PARALELO_SERIAL_WORDCNT_EN
      words_sent_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      slice_cnt_q  <= slice_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      word_start_q <= word_start_d;
      idle_out_q   <= idle_out_d;
`ifdef PARALELO_SERIAL_WORDCNT_EN
      words_sent_q <= words_sent_d;
`endif
    end
  end

  assign serial_out = shreg_q[DATA_W-1 -: LANE_W];
  assign word_start = word_start_q;
  assign idle_out   = idle_out_q;
  assign active     = (state_q == StActive);
`ifdef PARALELO_SERIAL_WORDCNT_EN
  assign words_sent = words_sent_q;
`endif

endmodule
